booth_divider: RTL



---
 rtl/booth_divider.sv | 117 +++++++++++
 1 files changed

// File: rtl/booth_divider.sv
// Signed N-bit sequential divider: non-restoring iteration on magnitudes, then one sign-fix cycle.
// Latency N+1 cycles from the load edge; load restarts at any time, results hold until the next load.
module booth_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N:0]    p;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [N-1:0]  dvd;
  logic          sign_q;
  logic          sign_r;
  logic          dz;

  logic [N-1:0]  mag_a;
  logic [N-1:0]  mag_b;
  logic [N:0]    d_ext;
  logic [N:0]    p_sh;
  logic [N:0]    p_step;
  logic [N:0]    p_fix;
  logic [N-1:0]  r_mag;

  // Magnitudes are N-bit unsigned so the most negative operand still fits.
  assign mag_a = dividend[N-1] ? -dividend : dividend;
  assign mag_b = divisor[N-1]  ? -divisor  : divisor;

  // The partial remainder stays within [-2D, 2D), so N+1 signed bits suffice.
  always_comb begin
    d_ext  = {1'b0, d};
    p_sh   = {p[N-1:0], q[N-1]};
    p_step = p[N] ? (p_sh + d_ext) : (p_sh - d_ext);
    p_fix  = p[N] ? (p + d_ext) : p;
    r_mag  = p_fix[N-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = ITER;
    end else begin
      case (state)
        ITER:    if (cnt == CW'(N - 1)) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      dvd         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (load) begin
      cnt         <= '0;
      p           <= '0;
      q           <= mag_a;
      d           <= mag_b;
      dvd         <= dividend;
      sign_q      <= dividend[N-1] ^ divisor[N-1];
      sign_r      <= dividend[N-1];
      dz          <= (divisor == '0);
      div_by_zero <= 1'b0;
    end else if (state == ITER) begin
      p   <= p_step;
      q   <= {q[N-2:0], ~p_step[N]};
      cnt <= cnt + CW'(1);
    end else if (state == FIX) begin
      p <= p_fix;
      if (dz) begin
        quotient    <= '1;
        remainder   <= dvd;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= sign_q ? -q : q;
        remainder   <= sign_r ? -r_mag : r_mag;
      end
    end
  end

  assign busy = (state == ITER) || (state == FIX);
  assign done = (state == DONE);

endmodule
